// File: rtl/dataclk_pll_sequencer.sv
// dataclk_pll_sequencer
// Sequences a reprogram of the SPI data clock PLL from the bus_clk domain.
// Accepts a new O/D/M divider set and holds off the SPI engine until it
// has drained. It then pulses the PLL reconfiguration trigger, waits for
// the reprogram to finish and for lock, and lets the clock settle before
// releasing the hold. Any wait that runs too long lands in ERROR.
//
// Ports
//   bus_clk, reset             : clock, synchronous active-high reset
//   cfg_req, cfg_O/D/M         : one-cycle request with requested divider set
//   clear_flags                : one-cycle clear of err_timeout / lock_lost
//   SPI_running                : async, SPI engine busy (dataclk domain)
//   PLL_prog_done              : async, clock_generator ready
//   dataclk_locked             : async, clock_generator locked
//   dataclk_O/D/M              : registered dividers to clock_generator
//   PLL_prog_trigger           : one-cycle reprogram start pulse
//   spi_hold                   : SPI must not start a new sequence
//   busy                       : sequence in progress
//   cfg_rejected               : one-cycle pulse on a refused request
//   err_timeout, lock_lost     : sticky status flags
//
// state      | meaning
// S_IDLE     | waiting for a request; lock monitor active after first sequence
// S_DRAIN    | SPI held, waiting for in-flight acquisition to stop
// S_PROG     | single cycle, trigger pulse to the PLL
// S_WSTART   | waiting for ready to drop (reprogram started)
// S_WDONE    | waiting for ready to return (reprogram finished)
// S_WLOCK    | waiting for lock
// S_SETTLE   | lock seen, guard time before releasing the SPI hold
// S_ERROR    | a wait timed out; SPI stays held, new requests accepted
module dataclk_pll_sequencer #(
    parameter logic [7:0]  DEFAULT_O      = 8'd40,
    parameter logic [3:0]  DEFAULT_D      = 4'd1,
    parameter logic [6:0]  DEFAULT_M      = 7'd42,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd2_500_000,
    parameter logic [15:0] SETTLE_CYCLES  = 16'd256
) (
    input  logic       bus_clk,
    input  logic       reset,
    input  logic       cfg_req,
    input  logic [7:0] cfg_O,
    input  logic [3:0] cfg_D,
    input  logic [6:0] cfg_M,
    input  logic       clear_flags,
    input  logic       SPI_running,
    input  logic       PLL_prog_done,
    input  logic       dataclk_locked,
    output logic [7:0] dataclk_O,
    output logic [3:0] dataclk_D,
    output logic [6:0] dataclk_M,
    output logic       PLL_prog_trigger,
    output logic       spi_hold,
    output logic       busy,
    output logic       cfg_rejected,
    output logic       err_timeout,
    output logic       lock_lost
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRAIN  = 3'd1,
        S_PROG   = 3'd2,
        S_WSTART = 3'd3,
        S_WDONE  = 3'd4,
        S_WLOCK  = 3'd5,
        S_SETTLE = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    state_t      state_q;
    logic [1:0]  run_sync_q, rdy_sync_q, lck_sync_q;
    logic        run_s, rdy_s, lck_s;
    logic        lck_prev_q;
    logic        done_once_q;
    logic [31:0] tmr_q;
    logic [31:0] tmr_d;
    logic [15:0] settle_q;
    logic [7:0]  div_o_q;
    logic [3:0]  div_d_q;
    logic [6:0]  div_m_q;
    logic        trig_q, hold_q, busy_q, rej_q, err_q, lost_q;
    logic        cfg_valid, can_accept, accept, tmo_hit, lock_fell;

    assign run_s = run_sync_q[1];
    assign rdy_s = rdy_sync_q[1];
    assign lck_s = lck_sync_q[1];

    assign cfg_valid  = (cfg_O != 8'd0) && (cfg_D != 4'd0) && (cfg_M >= 7'd2);
    assign can_accept = (state_q == S_IDLE) || (state_q == S_ERROR);
    assign accept     = cfg_req && cfg_valid && can_accept;
    assign tmo_hit    = (tmr_q == TIMEOUT_CYCLES - 32'd1);
    assign tmr_d      = tmr_q + 32'd1;
    // Only meaningful once the PLL has been brought up by this block.
    assign lock_fell  = (state_q == S_IDLE) && done_once_q && lck_prev_q && !lck_s;

    always_ff @(posedge bus_clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            run_sync_q  <= 2'b00;
            rdy_sync_q  <= 2'b00;
            lck_sync_q  <= 2'b00;
            lck_prev_q  <= 1'b0;
            done_once_q <= 1'b0;
            tmr_q       <= 32'd0;
            settle_q    <= 16'd0;
            div_o_q     <= DEFAULT_O;
            div_d_q     <= DEFAULT_D;
            div_m_q     <= DEFAULT_M;
            trig_q      <= 1'b0;
            hold_q      <= 1'b0;
            busy_q      <= 1'b0;
            rej_q       <= 1'b0;
            err_q       <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            run_sync_q <= {run_sync_q[0], SPI_running};
            rdy_sync_q <= {rdy_sync_q[0], PLL_prog_done};
            lck_sync_q <= {lck_sync_q[0], dataclk_locked};
            lck_prev_q <= lck_s;
            trig_q     <= 1'b0;
            rej_q      <= cfg_req && !accept;

            if (clear_flags) begin
                err_q  <= 1'b0;
                lost_q <= 1'b0;
            end

            // In every timed wait the exit condition is checked before the
            // timeout, so an event arriving on the last allowed cycle wins.
            case (state_q)
                S_IDLE, S_ERROR: begin
                    if (accept) begin
                        div_o_q <= cfg_O;
                        div_d_q <= cfg_D;
                        div_m_q <= cfg_M;
                        err_q   <= 1'b0;
                        lost_q  <= 1'b0;
                        tmr_q   <= 32'd0;
                        busy_q  <= 1'b1;
                        hold_q  <= 1'b1;
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!run_s) begin
                        trig_q  <= 1'b1;
                        state_q <= S_PROG;
                    end else if (tmo_hit) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_ERROR;
                    end else begin
                        tmr_q <= tmr_d;
                    end
                end
                S_PROG: begin
                    tmr_q   <= 32'd0;
                    state_q <= S_WSTART;
                end
                S_WSTART: begin
                    if (!rdy_s) begin
                        tmr_q   <= 32'd0;
                        state_q <= S_WDONE;
                    end else if (tmo_hit) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_ERROR;
                    end else begin
                        tmr_q <= tmr_d;
                    end
                end
                S_WDONE: begin
                    if (rdy_s) begin
                        tmr_q   <= 32'd0;
                        state_q <= S_WLOCK;
                    end else if (tmo_hit) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_ERROR;
                    end else begin
                        tmr_q <= tmr_d;
                    end
                end
                S_WLOCK: begin
                    if (lck_s) begin
                        settle_q <= 16'd0;
                        state_q  <= S_SETTLE;
                    end else if (tmo_hit) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_ERROR;
                    end else begin
                        tmr_q <= tmr_d;
                    end
                end
                S_SETTLE: begin
                    if (!lck_s) begin
                        settle_q <= 16'd0;
                    end else if (settle_q == SETTLE_CYCLES - 16'd1) begin
                        busy_q      <= 1'b0;
                        hold_q      <= 1'b0;
                        done_once_q <= 1'b1;
                        state_q     <= S_IDLE;
                    end else begin
                        settle_q <= settle_q + 16'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // A set in the same cycle beats any clear above.
            if (lock_fell) begin
                lost_q <= 1'b1;
            end
        end
    end

    assign dataclk_O        = div_o_q;
    assign dataclk_D        = div_d_q;
    assign dataclk_M        = div_m_q;
    assign PLL_prog_trigger = trig_q;
    assign spi_hold         = hold_q;
    assign busy             = busy_q;
    assign cfg_rejected     = rej_q;
    assign err_timeout      = err_q;
    assign lock_lost        = lost_q;

endmodule

// File: tb/tb_dataclk_pll_sequencer.sv
// Bench for dataclk_pll_sequencer: two instances (long and short timeout)
// share one stimulus; a behavioural model of both is compared every cycle,
// and directed literal checks pin the model's timing.
module tb_dataclk_pll_sequencer;

    localparam int P_IDLE   = 0;
    localparam int P_DRAIN  = 1;
    localparam int P_PROG   = 2;
    localparam int P_WSTART = 3;
    localparam int P_WDONE  = 4;
    localparam int P_WLOCK  = 5;
    localparam int P_SETTLE = 6;
    localparam int P_ERROR  = 7;
    localparam int SETTLE   = 256;

    logic       bus_clk;
    logic       reset;
    logic       cfg_req;
    logic [7:0] cfg_O;
    logic [3:0] cfg_D;
    logic [6:0] cfg_M;
    logic       clear_flags;
    logic       SPI_running;
    logic       PLL_prog_done;
    logic       dataclk_locked;

    logic [7:0] d_O    [2];
    logic [3:0] d_D    [2];
    logic [6:0] d_M    [2];
    logic       d_trig [2];
    logic       d_hold [2];
    logic       d_busy [2];
    logic       d_rej  [2];
    logic       d_err  [2];
    logic       d_lost [2];

    dataclk_pll_sequencer #(.TIMEOUT_CYCLES(32'd1500)) u_dut0 (
        .bus_clk(bus_clk), .reset(reset), .cfg_req(cfg_req),
        .cfg_O(cfg_O), .cfg_D(cfg_D), .cfg_M(cfg_M), .clear_flags(clear_flags),
        .SPI_running(SPI_running), .PLL_prog_done(PLL_prog_done),
        .dataclk_locked(dataclk_locked),
        .dataclk_O(d_O[0]), .dataclk_D(d_D[0]), .dataclk_M(d_M[0]),
        .PLL_prog_trigger(d_trig[0]), .spi_hold(d_hold[0]), .busy(d_busy[0]),
        .cfg_rejected(d_rej[0]), .err_timeout(d_err[0]), .lock_lost(d_lost[0])
    );

    dataclk_pll_sequencer #(.TIMEOUT_CYCLES(32'd100)) u_dut1 (
        .bus_clk(bus_clk), .reset(reset), .cfg_req(cfg_req),
        .cfg_O(cfg_O), .cfg_D(cfg_D), .cfg_M(cfg_M), .clear_flags(clear_flags),
        .SPI_running(SPI_running), .PLL_prog_done(PLL_prog_done),
        .dataclk_locked(dataclk_locked),
        .dataclk_O(d_O[1]), .dataclk_D(d_D[1]), .dataclk_M(d_M[1]),
        .PLL_prog_trigger(d_trig[1]), .spi_hold(d_hold[1]), .busy(d_busy[1]),
        .cfg_rejected(d_rej[1]), .err_timeout(d_err[1]), .lock_lost(d_lost[1])
    );

    initial bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_print = 0;
    logic cmp_en = 1'b0;
    int trig_cnt = 0;

    // ---------------- behavioural model ----------------
    int         tov    [2] = '{1500, 100};
    int         m_ph   [2] = '{0, 0};
    int         m_cnt  [2] = '{0, 0};
    logic [7:0] m_O    [2];
    logic [3:0] m_D    [2];
    logic [6:0] m_M    [2];
    logic       m_rej  [2];
    logic       m_err  [2];
    logic       m_lost [2];
    logic       m_done [2];
    logic [1:0] run_p = 2'b00, rdy_p = 2'b00, lck_p = 2'b00;
    logic       m_lprev = 1'b0;

    task automatic model_step(input int k, input logic rs, input logic ys,
                              input logic ls, input logic lprev);
        int   ph;
        logic acc;
        logic was_done;
        logic go;
        ph       = m_ph[k];
        was_done = m_done[k];
        acc = cfg_req && cfg_O != 0 && cfg_D != 0 && cfg_M >= 2 &&
              (ph == P_IDLE || ph == P_ERROR);
        m_rej[k] = cfg_req && !acc;
        if (clear_flags) begin
            m_err[k]  = 1'b0;
            m_lost[k] = 1'b0;
        end
        if (ph == P_IDLE || ph == P_ERROR) begin
            if (acc) begin
                m_O[k] = cfg_O; m_D[k] = cfg_D; m_M[k] = cfg_M;
                m_err[k] = 1'b0; m_lost[k] = 1'b0;
                m_ph[k] = P_DRAIN; m_cnt[k] = 0;
            end
        end else if (ph == P_PROG) begin
            m_ph[k] = P_WSTART; m_cnt[k] = 0;
        end else if (ph == P_SETTLE) begin
            if (!ls) m_cnt[k] = 0;
            else if (m_cnt[k] == SETTLE - 1) begin
                m_ph[k] = P_IDLE; m_done[k] = 1'b1;
            end else m_cnt[k]++;
        end else begin
            // timed waits: each has one condition that advances to the next phase
            go = (ph == P_DRAIN)  ? !rs :
                 (ph == P_WSTART) ? !ys :
                 (ph == P_WDONE)  ?  ys : ls;
            if (go) begin
                m_ph[k] = ph + 1; m_cnt[k] = 0;
            end else if (m_cnt[k] == tov[k] - 1) begin
                m_ph[k] = P_ERROR; m_err[k] = 1'b1;
            end else m_cnt[k]++;
        end
        if (ph == P_IDLE && was_done && lprev && !ls) m_lost[k] = 1'b1;
    endtask

    always @(posedge bus_clk) begin
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                m_ph[k] = P_IDLE; m_cnt[k] = 0;
                m_O[k] = 8'd40; m_D[k] = 4'd1; m_M[k] = 7'd42;
                m_rej[k] = 0; m_err[k] = 0; m_lost[k] = 0; m_done[k] = 0;
            end
            run_p = 2'b00; rdy_p = 2'b00; lck_p = 2'b00; m_lprev = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++)
                model_step(k, run_p[1], rdy_p[1], lck_p[1], m_lprev);
            m_lprev = lck_p[1];
            run_p = {run_p[0], SPI_running};
            rdy_p = {rdy_p[0], PLL_prog_done};
            lck_p = {lck_p[0], dataclk_locked};
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [24:0] cmp_act, cmp_exp;
    always @(negedge bus_clk) begin
        if (cmp_en) begin
            if (d_trig[0] === 1'b1) trig_cnt++;
            for (int k = 0; k < 2; k++) begin
                cmp_act = {d_O[k], d_D[k], d_M[k], d_trig[k], d_hold[k],
                           d_busy[k], d_rej[k], d_err[k], d_lost[k]};
                cmp_exp = {m_O[k], m_D[k], m_M[k], m_ph[k] == P_PROG,
                           m_ph[k] != P_IDLE, m_ph[k] != P_IDLE && m_ph[k] != P_ERROR,
                           m_rej[k], m_err[k], m_lost[k]};
                n_total++;
                if (cmp_act === cmp_exp) n_pass++;
                else if (n_print < 20) begin
                    n_print++;
                    $display("FAIL model_cmp dut%0d t=%0t: got %h, expected %h",
                             k, $time, cmp_act, cmp_exp);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge bus_clk);
    endtask

    // leaves the caller at cycle 1 (first cycle after the request edge)
    task automatic req(input logic [7:0] o, input logic [3:0] d, input logic [6:0] m);
        @(negedge bus_clk);
        cfg_O = o; cfg_D = d; cfg_M = m; cfg_req = 1'b1;
        @(negedge bus_clk);
        cfg_req = 1'b0;
    endtask

    task automatic run_pll();
        tick(5);  PLL_prog_done = 1'b0; dataclk_locked = 1'b0;
        tick(20); PLL_prog_done = 1'b1;
        tick(20); dataclk_locked = 1'b1;
        tick(300);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cfg_req = 1'b0; cfg_O = 8'd0; cfg_D = 4'd0; cfg_M = 7'd0;
        clear_flags = 1'b0; SPI_running = 1'b0; PLL_prog_done = 1'b1;
        dataclk_locked = 1'b1;
        tick(3);
        reset = 1'b0;
        cmp_en = 1'b1;
        tick(4);
        // reset state
        for (int k = 0; k < 2; k++) begin
            chk("reset_O", d_O[k], 40);
            chk("reset_D", d_D[k], 1);
            chk("reset_M", d_M[k], 42);
            chk("reset_flags", {d_trig[k], d_hold[k], d_busy[k], d_rej[k], d_err[k], d_lost[k]}, 0);
        end

        // program, best case
        trig_cnt = 0;
        req(8'd20, 4'd1, 7'd40);
        chk("prog_busy_c1", d_busy[0], 1);
        chk("prog_O_c1", d_O[0], 20);
        chk("prog_M_c1", d_M[0], 40);
        chk("prog_trig_c1", d_trig[0], 0);
        tick(1);
        chk("prog_trig_c2", d_trig[0], 1);
        tick(5);  PLL_prog_done = 1'b0; dataclk_locked = 1'b0;
        tick(50); PLL_prog_done = 1'b1;
        tick(100); dataclk_locked = 1'b1;
        tick(258);
        chk("prog_hold_lock+256", d_hold[0], 1);
        tick(1);
        chk("prog_hold_lock+257", d_hold[0], 0);
        chk("prog_busy_end", d_busy[0], 0);
        chk("prog_trig_count", trig_cnt, 1);

        // drain
        SPI_running = 1'b1;
        tick(3);
        req(8'd30, 4'd2, 7'd50);
        tick(999);
        chk("drain_hold", d_hold[0], 1);
        chk("drain_no_trig", d_trig[0], 0);
        chk("drain_dut1_timeout", d_err[1], 1);
        SPI_running = 1'b0;
        tick(2);
        chk("drain_trig_fall+2", d_trig[0], 0);
        tick(1);
        chk("drain_trig_fall+3", d_trig[0], 1);
        run_pll();
        chk("drain_done_busy", d_busy[0], 0);

        // rejects: O=0, D=0, M=1
        req(8'd0, 4'd2, 7'd50);
        chk("rej_O0_pulse", d_rej[0], 1);
        chk("rej_O0_busy", d_busy[0], 0);
        req(8'd30, 4'd0, 7'd50);
        chk("rej_D0_pulse", d_rej[0], 1);
        chk("rej_D0_O", d_O[0], 30);
        tick(1);
        chk("rej_D0_pulse_end", d_rej[0], 0);
        req(8'd30, 4'd2, 7'd1);
        chk("rej_M1_pulse", d_rej[0], 1);
        chk("rej_M1_M", d_M[0], 50);
        req(8'd25, 4'd3, 7'd60);
        tick(2);
        req(8'd10, 4'd1, 7'd10);
        chk("rej_busy_pulse", d_rej[0], 1);
        chk("rej_busy_O", d_O[0], 25);
        chk("rej_busy_still_busy", d_busy[0], 1);
        run_pll();

        // timeout on the short-timeout instance: lock never returns
        req(8'd50, 4'd1, 7'd45);
        tick(1);
        tick(5);  PLL_prog_done = 1'b0; dataclk_locked = 1'b0;
        tick(20); PLL_prog_done = 1'b1;
        tick(102);
        chk("tmo_err_before", d_err[1], 0);
        tick(1);
        chk("tmo_err_set", d_err[1], 1);
        chk("tmo_hold", d_hold[1], 1);
        chk("tmo_busy", d_busy[1], 0);
        chk("tmo_dut0_err", d_err[0], 0);
        req(8'd60, 4'd2, 7'd70);
        chk("tmo_restart_err", d_err[1], 0);
        chk("tmo_restart_busy", d_busy[1], 1);
        chk("tmo_restart_O", d_O[1], 60);
        chk("tmo_dut0_rej", d_rej[0], 1);

        // mid-sequence reset during WAIT_DONE
        tick(1);
        tick(5); PLL_prog_done = 1'b0;
        tick(8);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("rst_O", d_O[1], 40);
        chk("rst_D", d_D[1], 1);
        chk("rst_M", d_M[1], 42);
        chk("rst_busy_hold", {d_busy[1], d_hold[1], d_trig[1]}, 0);

        // full sequence, then lock loss (M=2 boundary accepted)
        PLL_prog_done = 1'b1;
        tick(3);
        req(8'd8, 4'd1, 7'd2);
        chk("m2_accept_M", d_M[0], 2);
        tick(1);
        chk("m2_trig", d_trig[0], 1);
        run_pll();
        chk("ll_idle", d_busy[0], 0);
        chk("ll_before", d_lost[0], 0);
        dataclk_locked = 1'b0;
        tick(2);
        chk("ll_not_yet", d_lost[0], 0);
        tick(1);
        chk("ll_set", d_lost[0], 1);
        chk("ll_no_hold", d_hold[0], 0);
        tick(7); dataclk_locked = 1'b1;
        tick(20);
        chk("ll_sticky", d_lost[0], 1);
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        chk("ll_cleared", d_lost[0], 0);
        tick(3);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dataclk_pll_sequencer.md
# dataclk_pll_sequencer

Sequences reprogramming of the programmable SPI data clock. It runs in the `bus_clk` domain, between the control-register write path and the `clock_generator` PLL reconfiguration port. It takes a new O/D/M divider set from the host and holds off the SPI engine until in-flight acquisition has stopped. It then triggers the PLL reprogram, waits for the reprogram to complete and for lock, and reports status and faults back to the status registers.

## Interface
Parameters:
- `DEFAULT_O`, 8'd40: O divider driven from reset.
- `DEFAULT_D`, 4'd1: D divider driven from reset.
- `DEFAULT_M`, 7'd42: M multiplier driven from reset.
- `TIMEOUT_CYCLES`, 32'd2_500_000: per-wait-state limit (10 ms at 250 MHz).
- `SETTLE_CYCLES`, 16'd256: guard time after lock before the SPI hold is released.

Ports:
- `bus_clk` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `cfg_req` in 1: one-cycle request to apply `cfg_O`/`cfg_D`/`cfg_M`.
- `cfg_O` in 8, `cfg_D` in 4, `cfg_M` in 7: requested divider set.
- `clear_flags` in 1: one-cycle clear of the sticky flags.
- `SPI_running` in 1: asynchronous to `bus_clk` (dataclk domain).
- `PLL_prog_done` in 1: asynchronous; the `ready` output of `clock_generator`.
- `dataclk_locked` in 1: asynchronous; the `locked` output of `clock_generator`.
- `dataclk_O` out 8, `dataclk_D` out 4, `dataclk_M` out 7: registered divider outputs to `clock_generator`.
- `PLL_prog_trigger` out 1: one-cycle start pulse to `clock_generator`.
- `spi_hold` out 1: while high, SPI_4x must not start a new sequence.
- `busy` out 1: a sequence is in progress.
- `cfg_rejected` out 1: one-cycle pulse when a request is refused.
- `err_timeout` out 1: sticky flag.
- `lock_lost` out 1: sticky flag.

## Operation
- Synchronizers:
  - `SPI_running`, `PLL_prog_done` and `dataclk_locked` each pass through a 2-FF synchronizer.
  - The synchronized signals are `run_s`, `rdy_s` and `lck_s`. All decisions below use these.
- Request validation:
  - A request is refused with a `cfg_rejected` pulse, and no state change, when any of these hold: `cfg_O==0`, `cfg_D==0`, `cfg_M<2`, or the FSM is not in IDLE or ERROR.
- FSM states: IDLE, DRAIN, PROG, WAIT_START, WAIT_DONE, WAIT_LOCK, SETTLE, ERROR.
  - IDLE/ERROR: on an accepted `cfg_req`:
    - latch the divider set into `dataclk_O/D/M`;
    - clear `err_timeout` and `lock_lost`;
    - go to DRAIN.
  - DRAIN: `spi_hold`=1. When `run_s`==0, go to PROG.
  - PROG: exactly one cycle; `PLL_prog_trigger`=1; then go to WAIT_START.
  - WAIT_START: wait for `rdy_s`==0 (reprogram has begun), then go to WAIT_DONE.
  - WAIT_DONE: wait for `rdy_s`==1, then go to WAIT_LOCK.
  - WAIT_LOCK: wait for `lck_s`==1, then go to SETTLE.
  - SETTLE:
    - count `SETTLE_CYCLES` cycles and go to IDLE.
    - If `lck_s` drops during SETTLE, the counter restarts.
  - ERROR: reached on timeout.
    - `spi_hold` stays 1 because dataclk is untrusted.
    - `busy`=0; new requests are accepted.
- Timeout:
  - A 32-bit counter is zeroed on entry to each of DRAIN, WAIT_START, WAIT_DONE and WAIT_LOCK.
  - Reaching `TIMEOUT_CYCLES-1` in any of these states sets `err_timeout` and goes to ERROR.
- Outputs per state:
  - `busy`=1 in every state except IDLE and ERROR.
  - `spi_hold`=1 in DRAIN through SETTLE and in ERROR.
- Lock monitor: in IDLE, after at least one completed sequence, a falling `lck_s` sets `lock_lost`. `spi_hold` is not asserted by this.
- Flag precedence:
  - `clear_flags` clears both sticky flags.
  - A set condition in the same cycle wins over the clear.
- Divider outputs change only on an accepted request.

## Timing
- Reset values:
  - `dataclk_O/D/M` = `DEFAULT_O/D/M`;
  - `PLL_prog_trigger`, `spi_hold`, `busy`, `cfg_rejected`, `err_timeout`, `lock_lost` = 0;
  - state = IDLE;
  - timers = 0;
  - "completed" flag = 0.
- Best-case latency with `run_s`=0, request at cycle 0:
  - `busy` and the new dividers are visible at cycle 1 (DRAIN).
  - `PLL_prog_trigger` is high during cycle 2 only.
  - Dividers are therefore stable for at least 1 cycle before the trigger.
- Best-case completion: `spi_hold` falls `SETTLE_CYCLES`+1 cycles after `lck_s` is first seen high, assuming lock holds through SETTLE.
- Asynchronous inputs carry 2 cycles of synchronizer delay before they are acted on.
- `reset` asserted mid-sequence:
  - returns to IDLE next cycle with all reset values;
  - an in-flight trigger is not reissued.
- `cfg_req` and `clear_flags` in the same cycle, request accepted: flags clear and the sequence starts.

## Test plan
- Reset, then hold `reset`=0 with no request: dividers read 40/1/42 and all flags are 0.
- Program:
  - Stimulus: `cfg_req` with O=20, D=1, M=40; `SPI_running`=0; model drops ready 5 cycles after the trigger, raises it after 50 cycles, raises locked 100 cycles later.
  - Required: exactly one trigger pulse at cycle 2; dividers are 20/1/40 from cycle 1; `spi_hold` falls 257 cycles after lock is seen; `busy` then 0.
- Drain:
  - Stimulus: request while `SPI_running`=1 for 1000 cycles.
  - Required: no trigger until 3 cycles after `SPI_running` falls; `spi_hold`=1 throughout.
- Reject:
  - Stimulus: request with D=0; separately, a second request while `busy`.
  - Required: each gives a one-cycle `cfg_rejected` pulse; dividers and state are unchanged.
- Timeout (bench sets `TIMEOUT_CYCLES`=100):
  - Stimulus: locked never rises.
  - Required: `err_timeout`=1 100 cycles after WAIT_LOCK entry; `spi_hold` stays 1; a new valid request clears the flag and restarts the sequence.
- Lock loss and mid-sequence reset:
  - Lock loss stimulus: after a completed sequence, drop locked for 10 cycles. Required: `lock_lost` set and held until `clear_flags`.
  - Reset stimulus: `reset` during WAIT_DONE. Required: IDLE with default dividers on the next cycle.
